prog_ram_arbiter: RTL and testbench
===================================

Name: prog_ram_arbiter

Overview:
Sits directly downstream of the UART program loader and consumes its RAM write stream (waddr/wdata/write_en) and its control strobes (ask_for_ram, end_of_data).
Owns the single write/address port of the shared program RAM and hands it to either the 6502 core or the loader.
Halts the CPU safely through RDY before granting the loader, and sequences the CPU reset after a download.
Also generates the power-on CPU reset.

Parameters:
ADDR_W, 16, RAM/CPU address width
RESET_CYCLES, 8, minimum cycles cpu_reset is held high (power-on and post-download)
DRAIN_MAX, 7, maximum cycles to wait for CPU write cycles to finish after RDY drops

Ports:
clk_ram  in  1  RAM/system clock
reset  in  1  synchronous, active-high
prog_waddr  in  ADDR_W  loader write address
prog_wdata  in  8  loader write data
prog_we  in  1  loader write enable
ask_for_ram  in  1  loader requests RAM (level)
end_of_data  in  1  loader signals download complete (level, multi-cycle)
cpu_addr  in  ADDR_W  CPU address bus
cpu_dout  in  8  CPU write data
cpu_we  in  1  CPU write strobe
ram_addr  out  ADDR_W  muxed RAM address
ram_din  out  8  muxed RAM write data
ram_we  out  1  muxed RAM write enable
cpu_rdy  out  1  CPU RDY (low = halt on read cycle)
cpu_reset  out  1  CPU reset, active-high
prog_grant  out  1  loader currently owns RAM port
drop_cnt  out  8  loader writes discarded while not granted, saturating at 255
drain_timeout  out  1  sticky: drain exceeded DRAIN_MAX

Behaviour:
- State register encodings: BOOT, RUN, DRAIN, PROG, RST_HOLD.
- Mux is combinational from the registered state, so routing latency is 0 cycles.
- On reset: state=BOOT, hold counter=0, drain counter=0, drop_cnt=0, drain_timeout=0.
- Reset values at the outputs: cpu_reset=1, cpu_rdy=1, prog_grant=0, ram_we=0.
- Mid-operation reset aborts any state and returns to BOOT.
- BOOT:
  - cpu_reset=1, cpu_rdy=1, CPU owns the mux with ram_we forced 0.
  - Counter runs to RESET_CYCLES-1, then the state goes to RUN.
  - If ask_for_ram=1, go to PROG immediately; no drain is needed because the CPU is in reset.
- RUN:
  - CPU owns the port: ram_addr=cpu_addr, ram_din=cpu_dout, ram_we=cpu_we; cpu_rdy=1, cpu_reset=0.
  - ask_for_ram=1 → DRAIN, with cpu_rdy=0 from the next cycle.
- DRAIN:
  - cpu_rdy=0; CPU still owns the port, because the 6502 completes write cycles (up to 3 consecutive pushes) despite RDY.
  - cpu_we=0 for 1 cycle → PROG.
  - Drain counter reaching DRAIN_MAX → PROG and set drain_timeout.
  - ask_for_ram dropping during DRAIN → RUN (cpu_rdy back to 1).
- PROG:
  - Loader owns the port: ram_addr=prog_waddr, ram_din=prog_wdata, ram_we=prog_we; prog_grant=1, cpu_rdy=0, cpu_reset=0.
  - cpu_we is ignored.
  - end_of_data=1 → RST_HOLD, hold counter cleared.
  - ask_for_ram=0 with end_of_data=0 → RUN (resume without reset).
  - If both conditions hold in the same cycle, end_of_data wins.
- RST_HOLD:
  - cpu_reset=1, cpu_rdy=1; loader keeps the port (prog_grant=1), so its trailing writes still land.
  - Exit to RUN only when the counter has reached RESET_CYCLES-1 AND end_of_data=0.
  - ask_for_ram=1 while end_of_data=0 → PROG (a new transmission started).
- drop_cnt: increments when prog_we=1 and prog_grant=0 (in RUN/DRAIN/BOOT); it saturates at 255 and never wraps.
- Counters are 8 bits wide; RESET_CYCLES and DRAIN_MAX must each be ≤255.

Decomposition:
- Shared package holds the state encodings (3-bit localparams) and the default RESET_CYCLES and DRAIN_MAX.
- One natural sub-module, sat_counter8: saturating 8-bit counter with clear/enable. It is used for drop_cnt and, with clear, for the hold and drain counters.

Test Plan:
- Reset, then idle with RESET_CYCLES=8 → cpu_reset=1 for exactly 8 cycles after reset deasserts, then cpu_reset=0, cpu_rdy=1, and ram_* tracks cpu_* (cpu_addr=0x0200, cpu_we=1 → ram_we=1, ram_addr=0x0200).
- In RUN, assert ask_for_ram with cpu_we=1 for 3 cycles then 0 → cpu_rdy=0 the next cycle, 3 CPU writes reach RAM, prog_grant=1 one cycle after cpu_we falls, drain_timeout=0.
- In PROG, loader writes 0x600=0xA9 and 0x601=0x01 → ram_we/addr/data match. Then end_of_data high for 160 cycles with ask_for_ram low → cpu_reset=1 throughout and released on the cycle after end_of_data falls, then RUN.
- In DRAIN, hold cpu_we=1 for 10 cycles (DRAIN_MAX=7) → PROG entered after 7 cycles and drain_timeout=1 stays set until reset.
- In RUN, pulse prog_we 300 times without ask_for_ram → no RAM writes from the loader, drop_cnt=255.
- In RST_HOLD, assert reset, or re-raise ask_for_ram with end_of_data=0 → BOOT with cpu_reset=1 (for reset), or PROG with prog_grant=1 and cpu_reset=0 (for ask_for_ram).

Source files
------------

// File: rtl/prog_ram_arbiter_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// prog_ram_arbiter_pkg : shared state encodings and default timing constants
// Revision: 1.0
// ----------------------------------------------------------------------------
package prog_ram_arbiter_pkg;

  localparam logic [2:0] ST_BOOT     = 3'd0;
  localparam logic [2:0] ST_RUN      = 3'd1;
  localparam logic [2:0] ST_DRAIN    = 3'd2;
  localparam logic [2:0] ST_PROG     = 3'd3;
  localparam logic [2:0] ST_RST_HOLD = 3'd4;

  typedef enum logic [2:0] {
    BOOT     = ST_BOOT,
    RUN      = ST_RUN,
    DRAIN    = ST_DRAIN,
    PROG     = ST_PROG,
    RST_HOLD = ST_RST_HOLD
  } arb_state_e;

  localparam int DEF_RESET_CYCLES = 8;
  localparam int DEF_DRAIN_MAX    = 7;

endpackage
`default_nettype wire

// File: rtl/prog_ram_arbiter_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// prog_ram_arbiter_if : loader, CPU and RAM port bundle of the arbiter
// Revision: 1.0
// ----------------------------------------------------------------------------
interface prog_ram_arbiter_if #(
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] prog_waddr;
  logic [7:0]        prog_wdata;
  logic              prog_we;
  logic              ask_for_ram;
  logic              end_of_data;
  logic [ADDR_W-1:0] cpu_addr;
  logic [7:0]        cpu_dout;
  logic              cpu_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_din;
  logic              ram_we;
  logic              cpu_rdy;
  logic              cpu_reset;
  logic              prog_grant;
  logic [7:0]        drop_cnt;
  logic              drain_timeout;

  modport master (
    output prog_waddr, prog_wdata, prog_we, ask_for_ram, end_of_data,
    output cpu_addr, cpu_dout, cpu_we,
    input  ram_addr, ram_din, ram_we, cpu_rdy, cpu_reset, prog_grant,
    input  drop_cnt, drain_timeout
  );

  modport slave (
    input  prog_waddr, prog_wdata, prog_we, ask_for_ram, end_of_data,
    input  cpu_addr, cpu_dout, cpu_we,
    output ram_addr, ram_din, ram_we, cpu_rdy, cpu_reset, prog_grant,
    output drop_cnt, drain_timeout
  );
endinterface
`default_nettype wire

// File: rtl/prog_ram_arbiter_sat_counter8.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sat_counter8 : 8-bit up counter with clear (priority) and enable, sticks at 255
// Revision: 1.0
// ----------------------------------------------------------------------------
module sat_counter8 (
  input  wire logic       clk_ram,
  input  wire logic       reset,
  input  wire logic       clr_i,
  input  wire logic       en_i,
  output logic [7:0]      cnt_o
);
  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = 8'd0;
    else if (en_i && (cnt_q != 8'hFF))
      cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk_ram) begin
    if (reset)
      cnt_q <= 8'd0;
    else
      cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule
`default_nettype wire

// File: rtl/prog_ram_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// prog_ram_arbiter : hands the program RAM write port to the 6502 or the loader
// Revision: 1.0
// ----------------------------------------------------------------------------
module prog_ram_arbiter
  import prog_ram_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter int RESET_CYCLES = DEF_RESET_CYCLES,
  parameter int DRAIN_MAX    = DEF_DRAIN_MAX
) (
  input wire logic          clk_ram,
  input wire logic          reset,
  prog_ram_arbiter_if.slave bus
);
  localparam logic [7:0] HOLD_LAST  = 8'(RESET_CYCLES - 1);
  localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_MAX - 1);

  arb_state_e state_q;
  arb_state_e state_d;
  logic       timeout_q;
  logic       timeout_d;
  logic [7:0] hold_cnt;
  logic [7:0] drain_cnt;
  logic [7:0] drop_cnt;
  logic       grant;
  logic       cpu_drives_we;

  always_ff @(posedge clk_ram) begin
    if (reset) begin
      state_q   <= BOOT;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timeout_q <= timeout_d;
    end
  end

  // end_of_data outranks a dropped ask_for_ram in PROG; RST_HOLD waits for it to fall
  always_comb begin
    state_d   = state_q;
    timeout_d = timeout_q;
    case (state_q)
      BOOT: begin
        if (bus.ask_for_ram)
          state_d = PROG;
        else if (hold_cnt >= HOLD_LAST)
          state_d = RUN;
      end
      RUN: begin
        if (bus.ask_for_ram)
          state_d = DRAIN;
      end
      DRAIN: begin
        if (!bus.ask_for_ram)
          state_d = RUN;
        else if (!bus.cpu_we)
          state_d = PROG;
        else if (drain_cnt >= DRAIN_LAST) begin
          state_d   = PROG;
          timeout_d = 1'b1;
        end
      end
      PROG: begin
        if (bus.end_of_data)
          state_d = RST_HOLD;
        else if (!bus.ask_for_ram)
          state_d = RUN;
      end
      RST_HOLD: begin
        if (!bus.end_of_data) begin
          if (bus.ask_for_ram)
            state_d = PROG;
          else if (hold_cnt >= HOLD_LAST)
            state_d = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  // Hold counter is shared by BOOT and RST_HOLD; PROG always sits between them
  sat_counter8 u_hold_cnt (
    .clk_ram (clk_ram),
    .reset   (reset),
    .clr_i   (!((state_q == BOOT) || (state_q == RST_HOLD))),
    .en_i    (1'b1),
    .cnt_o   (hold_cnt)
  );

  sat_counter8 u_drain_cnt (
    .clk_ram (clk_ram),
    .reset   (reset),
    .clr_i   (state_q != DRAIN),
    .en_i    (1'b1),
    .cnt_o   (drain_cnt)
  );

  sat_counter8 u_drop_cnt (
    .clk_ram (clk_ram),
    .reset   (reset),
    .clr_i   (1'b0),
    .en_i    (bus.prog_we && !grant),
    .cnt_o   (drop_cnt)
  );

  assign grant         = (state_q == PROG) || (state_q == RST_HOLD);
  assign cpu_drives_we = (state_q == RUN) || (state_q == DRAIN);

  assign bus.ram_addr      = grant ? bus.prog_waddr : bus.cpu_addr;
  assign bus.ram_din       = grant ? bus.prog_wdata : bus.cpu_dout;
  assign bus.ram_we        = grant ? bus.prog_we : (cpu_drives_we && bus.cpu_we);
  assign bus.cpu_rdy       = !((state_q == DRAIN) || (state_q == PROG));
  assign bus.cpu_reset     = (state_q == BOOT) || (state_q == RST_HOLD);
  assign bus.prog_grant    = grant;
  assign bus.drop_cnt      = drop_cnt;
  assign bus.drain_timeout = timeout_q;
endmodule
`default_nettype wire

// File: tb/tb_prog_ram_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_prog_ram_arbiter : directed scenarios plus random traffic against a model
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_prog_ram_arbiter;
  localparam int AW = 16;
  localparam int RC = 8;
  localparam int DM = 7;

  logic clk_ram = 1'b0;
  logic reset   = 1'b1;
  always #5 clk_ram = ~clk_ram;

  prog_ram_arbiter_if #(.ADDR_W(AW)) bus ();

  prog_ram_arbiter #(
    .ADDR_W       (AW),
    .RESET_CYCLES (RC),
    .DRAIN_MAX    (DM)
  ) dut (
    .clk_ram (clk_ram),
    .reset   (reset),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_bad    = 0;

  // Model: who is in control, described as plain flags plus time spent there
  string m_phase;
  int    m_age;
  int    m_drops;
  bit    m_timeout;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic bit loader_owns();
    return (m_phase == "prog") || (m_phase == "hold");
  endfunction

  task automatic model_reset();
    m_phase = "boot"; m_age = 0; m_drops = 0; m_timeout = 0;
  endtask

  task automatic model_clock();
    string nxt;
    if (reset) begin
      model_reset();
      return;
    end
    if (bus.prog_we && !loader_owns() && m_drops < 255) m_drops++;
    nxt = m_phase;
    if (m_phase == "boot") begin
      if (bus.ask_for_ram) nxt = "prog";
      else if (m_age + 1 >= RC) nxt = "run";
    end else if (m_phase == "run") begin
      if (bus.ask_for_ram) nxt = "drain";
    end else if (m_phase == "drain") begin
      if (!bus.ask_for_ram) nxt = "run";
      else if (!bus.cpu_we) nxt = "prog";
      else if (m_age + 1 >= DM) begin nxt = "prog"; m_timeout = 1; end
    end else if (m_phase == "prog") begin
      if (bus.end_of_data) nxt = "hold";
      else if (!bus.ask_for_ram) nxt = "run";
    end else begin
      if (!bus.end_of_data && bus.ask_for_ram) nxt = "prog";
      else if (!bus.end_of_data && m_age + 1 >= RC) nxt = "run";
    end
    m_age   = (nxt == m_phase) ? m_age + 1 : 0;
    m_phase = nxt;
  endtask

  task automatic compare_outputs();
    bit lo = loader_owns();
    bit cpu_writes = (m_phase == "run") || (m_phase == "drain");
    check_val("ram_addr", 32'(bus.ram_addr), lo ? 32'(bus.prog_waddr) : 32'(bus.cpu_addr));
    check_val("ram_din", 32'(bus.ram_din), lo ? 32'(bus.prog_wdata) : 32'(bus.cpu_dout));
    check_val("ram_we", 32'(bus.ram_we), lo ? 32'(bus.prog_we) : 32'(cpu_writes && bus.cpu_we));
    check_val("cpu_rdy", 32'(bus.cpu_rdy), 32'(!(m_phase == "drain" || m_phase == "prog")));
    check_val("cpu_reset", 32'(bus.cpu_reset), 32'(m_phase == "boot" || m_phase == "hold"));
    check_val("prog_grant", 32'(bus.prog_grant), 32'(lo));
    check_val("drop_cnt", 32'(bus.drop_cnt), 32'(m_drops));
    check_val("drain_timeout", 32'(bus.drain_timeout), 32'(m_timeout));
  endtask

  task automatic step();
    @(negedge clk_ram);
    compare_outputs();
    @(posedge clk_ram);
    model_clock();
    #1;
  endtask

  initial begin
    int nw;
    bus.prog_waddr = '0; bus.prog_wdata = '0; bus.prog_we = 0;
    bus.ask_for_ram = 0; bus.end_of_data = 0;
    bus.cpu_addr = '0; bus.cpu_dout = '0; bus.cpu_we = 0;
    reset = 1;
    @(posedge clk_ram); #1;
    model_reset();
    step();
    check_val("rst_cpu_reset", 32'(bus.cpu_reset), 32'd1);
    check_val("rst_cpu_rdy", 32'(bus.cpu_rdy), 32'd1);
    check_val("rst_grant", 32'(bus.prog_grant), 32'd0);
    check_val("rst_ram_we", 32'(bus.ram_we), 32'd0);
    reset = 0;

    // Power-on reset length
    for (int i = 0; i < RC; i++) begin
      check_val("boot_hold", 32'(bus.cpu_reset), 32'd1);
      step();
    end
    check_val("boot_release", 32'(bus.cpu_reset), 32'd0);
    check_val("run_rdy", 32'(bus.cpu_rdy), 32'd1);
    bus.cpu_addr = 16'h0200; bus.cpu_dout = 8'h5A; bus.cpu_we = 1; #1;
    check_val("run_we", 32'(bus.ram_we), 32'd1);
    check_val("run_addr", 32'(bus.ram_addr), 32'h0200);
    step();

    // Drain with three trailing CPU writes
    bus.ask_for_ram = 1; nw = 0;
    for (int i = 0; i < 3; i++) begin
      if (bus.ram_we) nw++;
      step();
      check_val("drain_rdy", 32'(bus.cpu_rdy), 32'd0);
    end
    check_val("drain_writes", 32'(nw), 32'd3);
    bus.cpu_we = 0;
    check_val("drain_no_grant", 32'(bus.prog_grant), 32'd0);
    step();
    check_val("grant_after_drain", 32'(bus.prog_grant), 32'd1);
    check_val("no_timeout", 32'(bus.drain_timeout), 32'd0);

    // Loader writes, then long end_of_data
    bus.prog_waddr = 16'h0600; bus.prog_wdata = 8'hA9; bus.prog_we = 1; #1;
    check_val("ld_addr0", 32'(bus.ram_addr), 32'h0600);
    check_val("ld_data0", 32'(bus.ram_din), 32'hA9);
    step();
    bus.prog_waddr = 16'h0601; bus.prog_wdata = 8'h01; #1;
    check_val("ld_we1", 32'(bus.ram_we), 32'd1);
    check_val("ld_data1", 32'(bus.ram_din), 32'h01);
    step();
    bus.prog_we = 0; bus.ask_for_ram = 0; bus.end_of_data = 1;
    for (int i = 0; i < 160; i++) begin
      step();
      check_val("eod_reset", 32'(bus.cpu_reset), 32'd1);
    end
    bus.end_of_data = 0;
    step();
    check_val("eod_release", 32'(bus.cpu_reset), 32'd0);
    check_val("eod_run_grant", 32'(bus.prog_grant), 32'd0);

    // Drain timeout
    bus.ask_for_ram = 1; bus.cpu_we = 1;
    step();
    for (int i = 0; i < DM; i++) begin
      check_val("to_wait", 32'(bus.prog_grant), 32'd0);
      step();
    end
    check_val("to_grant", 32'(bus.prog_grant), 32'd1);
    check_val("to_flag", 32'(bus.drain_timeout), 32'd1);
    for (int i = 0; i < 3; i++) step();
    bus.ask_for_ram = 0; bus.cpu_we = 0;
    step();
    check_val("to_sticky", 32'(bus.drain_timeout), 32'd1);

    // Dropped loader writes while CPU owns the port
    for (int i = 0; i < 300; i++) begin
      bus.prog_we = 1; step();
      bus.prog_we = 0; step();
    end
    check_val("drop_sat", 32'(bus.drop_cnt), 32'd255);

    // Re-ask from RST_HOLD, then reset from RST_HOLD
    bus.ask_for_ram = 1;
    step(); step();
    bus.end_of_data = 1; step();
    check_val("hold_reset", 32'(bus.cpu_reset), 32'd1);
    bus.end_of_data = 0; step();
    check_val("reask_grant", 32'(bus.prog_grant), 32'd1);
    check_val("reask_cpu_reset", 32'(bus.cpu_reset), 32'd0);
    bus.end_of_data = 1; step();
    reset = 1; step();
    reset = 0;
    check_val("mid_rst_cpu_reset", 32'(bus.cpu_reset), 32'd1);
    check_val("mid_rst_grant", 32'(bus.prog_grant), 32'd0);
    check_val("mid_rst_drop", 32'(bus.drop_cnt), 32'd0);
    check_val("mid_rst_timeout", 32'(bus.drain_timeout), 32'd0);
    bus.end_of_data = 0; bus.ask_for_ram = 0;

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 15) == 0) bus.ask_for_ram = ~bus.ask_for_ram;
      if ($urandom_range(0, 23) == 0) bus.end_of_data = ~bus.end_of_data;
      bus.cpu_we     = ($urandom_range(0, 3) != 0);
      bus.prog_we    = $urandom_range(0, 1);
      bus.cpu_addr   = AW'($urandom);
      bus.cpu_dout   = 8'($urandom);
      bus.prog_waddr = AW'($urandom);
      bus.prog_wdata = 8'($urandom);
      reset          = ($urandom_range(0, 799) == 0);
      step();
    end
    reset = 0;

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
